lmem_access_scheduler: RTL and testbench

- Sequences the local memory (512-bit line store, byte-wide host port, full-width chunk port) and shares it between three requesters: host line load, host line dump, and compute-side chunk read.
- Round-robin arbitration; one transaction owns the memory until completion.
- Generates byte index, write/read strobes and per-requester done pulses.
- Replaces per-operation enable edges with level request / grant handshakes.

---
 rtl/lmem_access_scheduler.sv | 179 +++++++++++++++++
 tb/tb_lmem_access_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lmem_access_scheduler.sv
// Local memory access scheduler: shares one 512-bit line store between
// host line load, host line dump and compute-side chunk read. Round-robin
// arbitration with level request / registered grant; one transaction owns
// the memory until it completes.
module lmem_access_scheduler #(
  parameter int NUM_BITS  = 512,
  parameter int NUM_BYTES = NUM_BITS / 8,
  parameter int IDX_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_req,
  input  logic             dp_req,
  input  logic             ck_req,
  output logic             ld_gnt,
  output logic             dp_gnt,
  output logic             ck_gnt,
  input  logic             host_in_valid,
  input  logic [7:0]       host_in_data,
  output logic             host_in_ready,
  output logic             host_out_valid,
  output logic [7:0]       host_out_data,
  input  logic             host_out_ready,
  output logic [IDX_W-1:0] mem_idx,
  output logic             mem_byte_we,
  output logic [7:0]       mem_byte_wdata,
  input  logic [7:0]       mem_byte_rdata,
  output logic             mem_chunk_re,
  output logic             ld_done,
  output logic             dp_done,
  output logic             ck_valid,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    DUMP       = 3'd2,
    CHUNK_RD   = 3'd3,
    CHUNK_WAIT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RR_LOAD  = 2'd0,
    RR_DUMP  = 2'd1,
    RR_CHUNK = 2'd2
  } rr_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t           state, state_d;
  rr_t              rr, rr_d;
  logic [IDX_W-1:0] cnt, cnt_d;
  logic             ld_done_d, dp_done_d;
  logic             win_ld, win_dp, win_ck;

  // Round-robin pick: first asserted request in cyclic order after the last winner
  always_comb begin
    win_ld = 1'b0;
    win_dp = 1'b0;
    win_ck = 1'b0;
    case (rr)
      RR_LOAD: begin
        if (dp_req)      win_dp = 1'b1;
        else if (ck_req) win_ck = 1'b1;
        else if (ld_req) win_ld = 1'b1;
      end
      RR_DUMP: begin
        if (ck_req)      win_ck = 1'b1;
        else if (ld_req) win_ld = 1'b1;
        else if (dp_req) win_dp = 1'b1;
      end
      default: begin
        if (ld_req)      win_ld = 1'b1;
        else if (dp_req) win_dp = 1'b1;
        else if (ck_req) win_ck = 1'b1;
      end
    endcase
  end

  // Next-state, byte counter and per-state strobes
  always_comb begin
    state_d        = state;
    rr_d           = rr;
    cnt_d          = cnt;
    ld_done_d      = 1'b0;
    dp_done_d      = 1'b0;
    host_in_ready  = 1'b0;
    host_out_valid = 1'b0;
    host_out_data  = 8'h00;
    mem_byte_we    = 1'b0;
    mem_chunk_re   = 1'b0;
    ck_valid       = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (win_ld) begin
          state_d = LOAD;
          rr_d    = RR_LOAD;
        end else if (win_dp) begin
          state_d = DUMP;
          rr_d    = RR_DUMP;
        end else if (win_ck) begin
          state_d = CHUNK_RD;
          rr_d    = RR_CHUNK;
        end
      end
      LOAD: begin
        host_in_ready = 1'b1;
        mem_byte_we   = host_in_valid;
        if (host_in_valid) begin
          if (cnt == LAST_IDX) begin
            state_d   = IDLE;
            cnt_d     = '0;
            ld_done_d = 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      DUMP: begin
        host_out_valid = 1'b1;
        host_out_data  = mem_byte_rdata;
        if (host_out_ready) begin
          if (cnt == LAST_IDX) begin
            state_d   = IDLE;
            cnt_d     = '0;
            dp_done_d = 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      CHUNK_RD: begin
        mem_chunk_re = 1'b1;
        state_d      = CHUNK_WAIT;
      end
      CHUNK_WAIT: begin
        ck_valid = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, pointer, counter, registered grants and done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr      <= RR_CHUNK;
      cnt     <= '0;
      ld_gnt  <= 1'b0;
      dp_gnt  <= 1'b0;
      ck_gnt  <= 1'b0;
      ld_done <= 1'b0;
      dp_done <= 1'b0;
    end else begin
      state   <= state_d;
      rr      <= rr_d;
      cnt     <= cnt_d;
      ld_gnt  <= (state_d == LOAD);
      dp_gnt  <= (state_d == DUMP);
      ck_gnt  <= (state_d == CHUNK_RD) || (state_d == CHUNK_WAIT);
      ld_done <= ld_done_d;
      dp_done <= dp_done_d;
    end
  end

  // Memory-side index, write data and busy flag
  always_comb begin
    mem_idx        = cnt;
    mem_byte_wdata = host_in_data;
    busy           = (state != IDLE);
  end

endmodule

// File: tb/tb_lmem_access_scheduler.sv
// Self-checking bench for lmem_access_scheduler: per-cycle vector table for
// reset, arbitration and chunk timing, then hand-written load, dump,
// fairness and reset-mid-load sequences against a byte-wide memory model.
module tb_lmem_access_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_req, dp_req, ck_req;
  logic       ld_gnt, dp_gnt, ck_gnt;
  logic       host_in_valid;
  logic [7:0] host_in_data;
  logic       host_in_ready;
  logic       host_out_valid;
  logic [7:0] host_out_data;
  logic       host_out_ready;
  logic [5:0] mem_idx;
  logic       mem_byte_we;
  logic [7:0] mem_byte_wdata;
  logic [7:0] mem_byte_rdata;
  logic       mem_chunk_re;
  logic       ld_done, dp_done, ck_valid, busy;

  lmem_access_scheduler dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .dp_req(dp_req), .ck_req(ck_req),
    .ld_gnt(ld_gnt), .dp_gnt(dp_gnt), .ck_gnt(ck_gnt),
    .host_in_valid(host_in_valid), .host_in_data(host_in_data),
    .host_in_ready(host_in_ready),
    .host_out_valid(host_out_valid), .host_out_data(host_out_data),
    .host_out_ready(host_out_ready),
    .mem_idx(mem_idx), .mem_byte_we(mem_byte_we),
    .mem_byte_wdata(mem_byte_wdata), .mem_byte_rdata(mem_byte_rdata),
    .mem_chunk_re(mem_chunk_re),
    .ld_done(ld_done), .dp_done(dp_done), .ck_valid(ck_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Byte-wide view of the line store
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (mem_byte_we) mem[mem_idx] <= mem_byte_wdata;
  end
  assign mem_byte_rdata = mem[mem_idx];

  // Expected vector bit order:
  // {ld_gnt, dp_gnt, ck_gnt, busy, host_in_ready, host_out_valid,
  //  mem_byte_we, mem_chunk_re, ck_valid, ld_done, dp_done}
  typedef struct {
    logic        rst, ld, dp, ck, iv, ordy;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs [11];
  int   checks = 0;
  int   passes = 0;

  int         we_cnt, idx_err, done_cnt, data_err, stall_err, acc_cnt, mem_err, multi_err, n_gnt;
  logic [7:0] next_byte, stall_data;
  logic       accepted, got_last, last, have_stall;
  logic [1:0] seq [6];
  logic [1:0] cur, prev;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; ld_req = v.ld; dp_req = v.dp; ck_req = v.ck;
    host_in_valid = v.iv; host_out_ready = v.ordy; host_in_data = 8'h00;
  endtask

  function automatic logic [10:0] outVec();
    return {ld_gnt, dp_gnt, ck_gnt, busy, host_in_ready, host_out_valid,
            mem_byte_we, mem_chunk_re, ck_valid, ld_done, dp_done};
  endfunction

  initial begin
    vecs[0]  = '{1, 1, 1, 1, 1, 1, 11'b00000000000};
    vecs[1]  = '{1, 1, 1, 1, 1, 1, 11'b00000000000};
    vecs[2]  = '{0, 1, 1, 1, 0, 0, 11'b10011000000};
    vecs[3]  = '{0, 1, 1, 1, 1, 0, 11'b10011010000};
    vecs[4]  = '{1, 1, 1, 1, 0, 0, 11'b00000000000};
    vecs[5]  = '{0, 0, 0, 1, 0, 0, 11'b00110001000};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 11'b00110000100};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 11'b00000000000};
    vecs[8]  = '{0, 0, 1, 0, 0, 0, 11'b01010100000};
    vecs[9]  = '{1, 0, 1, 0, 0, 0, 11'b00000000000};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 11'b00000000000};

    applyStimulus(vecs[0]);
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d", i), 32'(outVec()), 32'(vecs[i].exp));
    end

    // Full line load with a valid gap every 4th cycle
    ld_req = 1; next_byte = 0; we_cnt = 0; idx_err = 0; done_cnt = 0; got_last = 0;
    for (int cyc = 0; cyc < 400 && !got_last; cyc++) begin
      host_in_valid = (cyc % 4) != 3;
      host_in_data  = next_byte;
      @(negedge clk);
      accepted = mem_byte_we && host_in_ready;
      if (mem_byte_we) begin
        we_cnt++;
        if (mem_idx !== next_byte[5:0]) idx_err++;
      end
      @(posedge clk); #1;
      if (ld_done) done_cnt++;
      if (accepted) begin
        if (next_byte == 8'h3F) got_last = 1;
        next_byte++;
      end
    end
    checkOutput("ld_last_reached", 32'(got_last), 32'd1);
    checkOutput("ld_done_after_last", 32'(ld_done), 32'd1);
    checkOutput("ld_busy_after_last", 32'(busy), 32'd0);
    ld_req = 0; host_in_valid = 0;
    @(posedge clk); #1;
    if (ld_done) done_cnt++;
    checkOutput("ld_done_count", 32'(done_cnt), 32'd1);
    checkOutput("ld_we_count", 32'(we_cnt), 32'd64);
    checkOutput("ld_idx_errors", 32'(idx_err), 32'd0);
    mem_err = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 8'(i)) mem_err++;
    checkOutput("ld_mem_contents", 32'(mem_err), 32'd0);

    // Dump with host_out_ready toggling 1,0
    dp_req = 1; next_byte = 0; data_err = 0; stall_err = 0; acc_cnt = 0;
    done_cnt = 0; got_last = 0; have_stall = 0;
    for (int cyc = 0; cyc < 400 && !got_last; cyc++) begin
      host_out_ready = (cyc % 2) == 0;
      last = 0;
      @(negedge clk);
      if (host_out_valid) begin
        if (have_stall && host_out_data !== stall_data) stall_err++;
        if (host_out_ready) begin
          if (host_out_data !== next_byte) data_err++;
          acc_cnt++;
          last = (next_byte == 8'h3F);
          next_byte++;
          have_stall = 0;
        end else begin
          have_stall = 1;
          stall_data = host_out_data;
        end
      end
      @(posedge clk); #1;
      if (dp_done) done_cnt++;
      if (last) got_last = 1;
    end
    checkOutput("dp_done_after_last", 32'(dp_done), 32'd1);
    checkOutput("dp_busy_after_last", 32'(busy), 32'd0);
    dp_req = 0; host_out_ready = 0;
    @(posedge clk); #1;
    if (dp_done) done_cnt++;
    checkOutput("dp_done_count", 32'(done_cnt), 32'd1);
    checkOutput("dp_byte_count", 32'(acc_cnt), 32'd64);
    checkOutput("dp_data_errors", 32'(data_err), 32'd0);
    checkOutput("dp_stall_errors", 32'(stall_err), 32'd0);

    // Fairness: all three requests held high after a fresh reset
    rst = 1;
    @(posedge clk); #1;
    rst = 0; ld_req = 1; dp_req = 1; ck_req = 1;
    host_in_valid = 1; host_in_data = 8'h00; host_out_ready = 1;
    n_gnt = 0; multi_err = 0; prev = 2'd0;
    for (int i = 0; i < 6; i++) seq[i] = 2'd0;
    for (int cyc = 0; cyc < 800 && n_gnt < 6; cyc++) begin
      @(posedge clk); #1;
      if ((32'(ld_gnt) + 32'(dp_gnt) + 32'(ck_gnt)) > 1) multi_err++;
      cur = ld_gnt ? 2'd1 : dp_gnt ? 2'd2 : ck_gnt ? 2'd3 : 2'd0;
      if (cur != 2'd0 && prev == 2'd0) begin
        seq[n_gnt] = cur;
        n_gnt++;
      end
      prev = cur;
    end
    ld_req = 0; dp_req = 0; ck_req = 0; host_in_valid = 0; host_out_ready = 0;
    checkOutput("fair_multi_grant", 32'(multi_err), 32'd0);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("fair_grant%0d", i), 32'(seq[i]), 32'((i % 3) + 1));
    for (int cyc = 0; cyc < 20 && busy; cyc++) begin
      @(posedge clk); #1;
    end
    checkOutput("fair_idle_after", 32'(busy), 32'd0);

    // Reset after 20 accepted load bytes, then restart
    ld_req = 1; host_in_valid = 1; acc_cnt = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 100 && acc_cnt < 20; cyc++) begin
      host_in_data = 8'hA0 + 8'(acc_cnt);
      @(negedge clk);
      accepted = mem_byte_we && host_in_ready;
      @(posedge clk); #1;
      if (ld_done) done_cnt++;
      if (accepted) acc_cnt++;
    end
    checkOutput("rst_ld_bytes", 32'(acc_cnt), 32'd20);
    checkOutput("rst_ld_idx_before", 32'(mem_idx), 32'd20);
    rst = 1;
    @(posedge clk); #1;
    if (ld_done) done_cnt++;
    checkOutput("rst_ld_busy", 32'(busy), 32'd0);
    checkOutput("rst_ld_gnt", 32'(ld_gnt), 32'd0);
    checkOutput("rst_ld_idx", 32'(mem_idx), 32'd0);
    rst = 0;
    @(posedge clk); #1;
    if (ld_done) done_cnt++;
    checkOutput("rst_ld_no_done", 32'(done_cnt), 32'd0);
    checkOutput("rst_ld_regrant", 32'(ld_gnt), 32'd1);
    checkOutput("rst_ld_restart_idx", 32'(mem_idx), 32'd0);
    ld_req = 0; host_in_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
